// File: rtl/morph_pkg.sv
// Shared constants, types and the window reduction for the 3x3 binary morphology block.
package morph_pkg;

   localparam logic MORPH_ERODE  = 1'b0;
   localparam logic MORPH_DILATE = 1'b1;
   localparam int   SYNC_DLY     = 2;

   typedef struct packed {
      logic vld;
      logic hs;
      logic vs;
   } sync_t;

   typedef logic [2:0] win_row_t;

   function automatic logic morph_op(input logic [8:0] win, input logic mode);
      return (mode == MORPH_DILATE) ? (|win) : (&win);
   endfunction

endpackage

// File: rtl/binary_morph_3x3_line_buffer.sv
// Two cascaded 1-bit line delays; tap1/tap2 give the same column one and two lines back.
// Latency: taps are registered state, shifted only on en. No backpressure.
module line_buffer_2taps #(
   parameter int DEPTH = 640
) (
   input  logic clk,
   input  logic en,
   input  logic din,
   output logic tap1,
   output logic tap2
);

   logic [DEPTH-1:0] line1_q, line1_d;
   logic [DEPTH-1:0] line2_q, line2_d;

   always_comb begin
      line1_d = line1_q;
      line2_d = line2_q;
      if (en) begin
         line1_d = {line1_q[DEPTH-2:0], din};
         line2_d = {line2_q[DEPTH-2:0], line1_q[DEPTH-1]};
      end
   end

   // Contents are deliberately not reset so the storage can map onto SRL/RAM.
   always_ff @(posedge clk) begin
      line1_q <= line1_d;
      line2_q <= line2_d;
   end

   assign tap1 = line1_q[DEPTH-1];
   assign tap2 = line2_q[DEPTH-1];

endmodule

// File: rtl/binary_morph_3x3.sv
// 3x3 binary erode/dilate on a 1-bit edge stream; optional border masking via BINARY_MORPH_BORDER_CLEAR_EN.
// Latency: 2 clk from input pixel to data_out, framing delayed to match.
// No backpressure: accepts one pixel per valid cycle, data_out holds between valid results.
module binary_morph_3x3
   import morph_pkg::*;
#(
   parameter int IMG_WIDTH = 640,
   parameter int CNT_WIDTH = 12
) (
   input  logic clk,
   input  logic reset_n,
   input  logic data_in,
   input  logic data_in_valid,
   input  logic data_in_hs,
   input  logic data_in_vs,
   input  logic mode,
   output logic data_out,
   output logic data_out_valid,
   output logic data_out_hs,
   output logic data_out_vs
);

   if (IMG_WIDTH < 4 || (2 ** CNT_WIDTH) <= IMG_WIDTH) begin : g_bad_param
      $error("binary_morph_3x3: IMG_WIDTH must be >= 4 and fit in CNT_WIDTH bits");
   end

   sync_t [SYNC_DLY-1:0] sync_q, sync_d;
   sync_t                sync_in;
   win_row_t [2:0]       win_q, win_d;
   logic                 mode_latched_q, mode_latched_d;
   logic                 data_out_q, data_out_d;
   logic                 tap1, tap2;
   logic                 active;
   logic                 vs_rise;
   logic                 border;

   line_buffer_2taps #(
      .DEPTH (IMG_WIDTH)
   ) u_line_buffer (
      .clk  (clk),
      .en   (data_in_valid),
      .din  (data_in),
      .tap1 (tap1),
      .tap2 (tap2)
   );

   assign active  = data_in_hs & data_in_vs;
   assign vs_rise = data_in_vs & ~sync_q[0].vs;

   always_comb begin
      sync_in.vld = data_in_valid;
      sync_in.hs  = data_in_hs;
      sync_in.vs  = data_in_vs;
      sync_d      = {sync_q[SYNC_DLY-2:0], sync_in};
   end

   // Row 2 is the live pixel, rows 1/0 come from the line taps; newest column in bit 0.
   always_comb begin
      win_d = win_q;
      if (!active) begin
         win_d = '0;
      end else if (data_in_valid) begin
         win_d[2] = {win_q[2][1:0], data_in};
         win_d[1] = {win_q[1][1:0], tap1};
         win_d[0] = {win_q[0][1:0], tap2};
      end
   end

   always_comb begin
      mode_latched_d = vs_rise ? mode : mode_latched_q;
   end

`ifdef BINARY_MORPH_BORDER_CLEAR_EN
   logic [CNT_WIDTH-1:0] col_cnt_q, col_cnt_d;
   logic [CNT_WIDTH-1:0] row_cnt_q, row_cnt_d;
   logic [CNT_WIDTH-1:0] col_pipe_q, col_pipe_d;
   logic [CNT_WIDTH-1:0] row_pipe_q, row_pipe_d;
   logic                 hs_fall;

   assign hs_fall = sync_q[0].hs & ~data_in_hs;

   always_comb begin
      col_cnt_d = col_cnt_q;
      if (!data_in_hs) begin
         col_cnt_d = '0;
      end else if (data_in_valid && (col_cnt_q != '1)) begin
         col_cnt_d = col_cnt_q + 1'b1;
      end

      row_cnt_d = row_cnt_q;
      if (!data_in_vs) begin
         row_cnt_d = '0;
      end else if (hs_fall && (row_cnt_q != '1)) begin
         row_cnt_d = row_cnt_q + 1'b1;
      end

      // Coordinates of the pixel being shifted in, aligned with the window next clk.
      col_pipe_d = col_cnt_q;
      row_pipe_d = row_cnt_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         col_cnt_q  <= '0;
         row_cnt_q  <= '0;
         col_pipe_q <= '0;
         row_pipe_q <= '0;
      end else begin
         col_cnt_q  <= col_cnt_d;
         row_cnt_q  <= row_cnt_d;
         col_pipe_q <= col_pipe_d;
         row_pipe_q <= row_pipe_d;
      end
   end

   assign border = (row_pipe_q < CNT_WIDTH'(2)) || (col_pipe_q < CNT_WIDTH'(2));
`else
   assign border = 1'b0;
`endif

   always_comb begin
      data_out_d = data_out_q;
      if (sync_q[0].vld) begin
         data_out_d = border ? 1'b0 : morph_op(win_q, mode_latched_q);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q         <= '0;
         win_q          <= '0;
         mode_latched_q <= MORPH_ERODE;
         data_out_q     <= 1'b0;
      end else begin
         sync_q         <= sync_d;
         win_q          <= win_d;
         mode_latched_q <= mode_latched_d;
         data_out_q     <= data_out_d;
      end
   end

   assign data_out       = data_out_q;
   assign data_out_valid = sync_q[SYNC_DLY-1].vld;
   assign data_out_hs    = sync_q[SYNC_DLY-1].hs;
   assign data_out_vs    = sync_q[SYNC_DLY-1].vs;

endmodule

// File: tb/tb_binary_morph_3x3.sv
// Directed bench for binary_morph_3x3 on 8x8 frames, with a per-cycle expected pipeline.
module tb_binary_morph_3x3;

   localparam int W  = 8;
   localparam int CW = 12;

   logic clk = 1'b0;
   logic reset_n;
   logic data_in, data_in_valid, data_in_hs, data_in_vs, mode;
   logic data_out, data_out_valid, data_out_hs, data_out_vs;

   always #5 clk = ~clk;

   binary_morph_3x3 #(
      .IMG_WIDTH (W),
      .CNT_WIDTH (CW)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .data_in        (data_in),
      .data_in_valid  (data_in_valid),
      .data_in_hs     (data_in_hs),
      .data_in_vs     (data_in_vs),
      .mode           (mode),
      .data_out       (data_out),
      .data_out_valid (data_out_valid),
      .data_out_hs    (data_out_hs),
      .data_out_vs    (data_out_vs)
   );

   int n_chk  = 0;
   int n_fail = 0;

   logic       hist [0:18];
   logic [7:0] img  [8];
   int         col_b, row_b;
   logic       vs_prev, hs_prev, frame_mode, e_last, mode_nxt;
   logic [3:0] d1, d2;
   bit         chk_dat;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic model_px();
      logic acc, b;
      acc = ~frame_mode;
      for (int j = 0; j < 3; j++) begin
         for (int k = 0; k < 3; k++) begin
            b   = (col_b >= k) ? hist[j*W + k] : 1'b0;
            acc = frame_mode ? (acc | b) : (acc & b);
         end
      end
`ifdef BINARY_MORPH_BORDER_CLEAR_EN
      if (row_b < 2 || col_b < 2) acc = 1'b0;
`endif
      return acc;
   endfunction

   task automatic model_reset();
      d1 = '0; d2 = '0; e_last = 1'b0; frame_mode = 1'b0;
      vs_prev = 1'b0; hs_prev = 1'b0; col_b = 0; row_b = 0;
   endtask

   // One clock: drive inputs, predict this pixel's output, check the one from 2 clk ago.
   task automatic cyc(input logic v, input logic h, input logic fv, input logic d);
      logic res;
      @(posedge clk); #1;
      data_in_valid = v; data_in_hs = h; data_in_vs = fv; data_in = d; mode = mode_nxt;
      if (fv && !vs_prev) frame_mode = mode_nxt;
      res = e_last;
      if (v) begin
         for (int i = 18; i > 0; i--) hist[i] = hist[i-1];
         hist[0] = d;
         res     = (h && fv) ? model_px() : 1'b0;
         e_last  = res;
      end
      if (!h) col_b = 0; else if (v) col_b++;
      if (!fv) row_b = 0; else if (hs_prev && !h) row_b++;
      hs_prev = h; vs_prev = fv;
      @(negedge clk);
      check_eq("sync", {data_out_valid, data_out_hs, data_out_vs}, d2[3:1]);
      if (chk_dat) check_eq("data_out", data_out, d2[0]);
      d2 = d1;
      d1 = {v, h, fv, res};
   endtask

   task automatic run_frame(input bit gapped, input int flip_row);
      repeat (3) cyc(0, 0, 0, 0);
      for (int r = 0; r < 8; r++) begin
         if (r == flip_row) mode_nxt = ~mode_nxt;
         repeat (2) cyc(0, 0, 1, 0);
         for (int c = 0; c < W; c++) begin
            if (gapped) begin
               for (int g = 0; g < 3 && $urandom_range(1, 0) == 1; g++)
                  cyc(0, 1, 1, 1'($urandom_range(1, 0)));
            end
            cyc(1, 1, 1, img[r][c]);
         end
      end
      repeat (2) cyc(0, 0, 1, 0);
      repeat (3) cyc(0, 0, 0, 0);
   endtask

   task automatic set_img(input logic fill);
      for (int r = 0; r < 8; r++) img[r] = {8{fill}};
   endtask

   initial begin
      for (int i = 0; i <= 18; i++) hist[i] = 1'b0;
      reset_n = 1'b0;
      data_in = 0; data_in_valid = 0; data_in_hs = 0; data_in_vs = 0; mode = 0;
      mode_nxt = 1'b0; chk_dat = 1'b1;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_sync", {data_out_valid, data_out_hs, data_out_vs}, 3'b000);
      check_eq("rst_data", data_out, 1'b0);
      reset_n = 1'b1;

      // Dilate: lone edge pixel grows into a 3x3 block
      mode_nxt = 1'b1;
      set_img(1'b0); img[4][4] = 1'b1;
      run_frame(0, -1);

      // Erode: solid frame, then solid frame with a single hole
      mode_nxt = 1'b0;
      set_img(1'b1);
      run_frame(0, -1);
      img[4][4] = 1'b0;
      run_frame(0, -1);

      // Mode toggled mid-frame only applies from the next vs rise
      set_img(1'b0);
      img[1] = 8'b0111_0110; img[2] = 8'b0111_0111; img[3] = 8'b0111_1111;
      img[5] = 8'b1000_0001; img[6] = 8'b1100_0011;
      run_frame(0, 3);
      run_frame(0, -1);

      // Gapped valid against the same contiguous stimulus
      mode_nxt = 1'b0;
      set_img(1'b1); img[2][5] = 1'b0; img[6][1] = 1'b0;
      run_frame(0, -1);
      run_frame(1, -1);
      mode_nxt = 1'b1;
      run_frame(1, -1);

      // Reset asserted in the middle of a line
      mode_nxt = 1'b0;
      repeat (2) cyc(0, 0, 0, 0);
      repeat (2) cyc(0, 0, 1, 0);
      for (int c = 0; c < W; c++) cyc(1, 1, 1, 1'b1);
      cyc(0, 0, 1, 0);
      for (int c = 0; c < 4; c++) cyc(1, 1, 1, 1'b1);
      @(posedge clk); #1;
      reset_n = 1'b0;
      data_in_valid = 0; data_in_hs = 0; data_in_vs = 0; data_in = 0;
      #1;
      check_eq("rst_mid_sync", {data_out_valid, data_out_hs, data_out_vs}, 3'b000);
      check_eq("rst_mid_data", data_out, 1'b0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      model_reset();
      // The lines fed before reset remain in the buffer and feed rows 0/1 of this frame.
      for (int i = 18; i >= 0; i--) hist[i] = (i < 12) ? 1'b1 : hist[i];
      mode_nxt = 1'b1;
      set_img(1'b0); img[4][4] = 1'b1; img[0][7] = 1'b1;
      run_frame(0, -1);

      // Random framing: only the 2-clk passthrough is predicted here
      chk_dat = 1'b0;
      for (int i = 0; i < 300; i++)
         cyc(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
             1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
